// File: rtl/axis_frame_tlast_gen.sv
// Frames a tlast-less AXI-Stream input into fixed-length frames and tags the last beat.
// The output is a two-entry skid buffer with a registered input-side ready.
module axis_frame_tlast_gen #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [LEN_WIDTH-1:0]  frame_len,
    output logic                  s_axis_tready,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tvalid,
    output logic                  busy,
    output logic [31:0]           frame_count
);

    typedef enum logic {StIdle, StRun} state_e;

    state_e                  state_q, state_d;
    logic [LEN_WIDTH-1:0]    len_q, len_d;
    logic [LEN_WIDTH-1:0]    beat_q, beat_d;
    logic [LEN_WIDTH-1:0]    len_eff;
    logic                    ready_q, ready_d;
    logic                    out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
    logic                    out_last_q, out_last_d;
    logic                    skid_valid_q, skid_valid_d;
    logic [DATA_WIDTH-1:0]   skid_data_q, skid_data_d;
    logic                    skid_last_q, skid_last_d;
    logic [31:0]             frame_count_q, frame_count_d;
    logic                    in_fire, out_fire, in_last;

    assign in_fire  = s_axis_tvalid && ready_q;
    assign out_fire = out_valid_q && m_axis_tready;
    // A zero length is treated as a single-beat frame.
    assign len_eff  = (len_q == '0) ? LEN_WIDTH'(1) : len_q;
    assign in_last  = (beat_q == len_eff - LEN_WIDTH'(1));

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        beat_d  = beat_q;
        unique case (state_q)
            StIdle: begin
                if (enable) begin
                    state_d = StRun;
                    len_d   = frame_len;
                    beat_d  = '0;
                end
            end
            StRun: begin
                if (in_fire) begin
                    if (in_last) begin
                        if (enable) begin
                            len_d  = frame_len;
                            beat_d = '0;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        beat_d = beat_q + LEN_WIDTH'(1);
                    end
                end
            end
        endcase
    end

    // Ready only ever admits a beat while the skid entry is empty, so an accepted
    // beat goes to the output register when it frees up, otherwise into the skid.
    always_comb begin
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        out_last_d    = out_last_q;
        skid_valid_d  = skid_valid_q;
        skid_data_d   = skid_data_q;
        skid_last_d   = skid_last_q;
        frame_count_d = frame_count_q;
        if (out_fire) begin
            out_valid_d = 1'b0;
            if (out_last_q) begin
                frame_count_d = frame_count_q + 32'd1;
            end
        end
        if (out_fire || !out_valid_q) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                out_last_d   = skid_last_q;
                skid_valid_d = 1'b0;
            end else if (in_fire) begin
                out_valid_d = 1'b1;
                out_data_d  = s_axis_tdata;
                out_last_d  = in_last;
            end
        end else if (in_fire) begin
            skid_valid_d = 1'b1;
            skid_data_d  = s_axis_tdata;
            skid_last_d  = in_last;
        end
        ready_d = (state_d == StRun) && !skid_valid_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            len_q         <= '0;
            beat_q        <= '0;
            ready_q       <= 1'b0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_last_q    <= 1'b0;
            skid_valid_q  <= 1'b0;
            skid_data_q   <= '0;
            skid_last_q   <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            beat_q        <= beat_d;
            ready_q       <= ready_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_last_q    <= out_last_d;
            skid_valid_q  <= skid_valid_d;
            skid_data_q   <= skid_data_d;
            skid_last_q   <= skid_last_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign s_axis_tready = ready_q;
    assign m_axis_tvalid = out_valid_q;
    assign m_axis_tdata  = out_data_q;
    assign m_axis_tlast  = out_last_q;
    assign busy          = (state_q == StRun);
    assign frame_count   = frame_count_q;

endmodule

// File: tb/tb_axis_frame_tlast_gen.sv
// Directed bench for axis_frame_tlast_gen: framing, stalls, enable drop, reset and length change.
module tb_axis_frame_tlast_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [15:0] frame_len;
    logic        s_axis_tready;
    logic [63:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        m_axis_tready;
    logic [63:0] m_axis_tdata;
    logic        m_axis_tlast;
    logic        m_axis_tvalid;
    logic        busy;
    logic [31:0] frame_count;

    int vecs = 0;
    int errs = 0;
    int cyc  = 0;

    logic [63:0] oq_data[$];
    bit          oq_last[$];
    int          oq_cyc[$];
    int          acc_cyc[$];

    axis_frame_tlast_gen #(
        .DATA_WIDTH(64),
        .LEN_WIDTH (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .frame_len    (frame_len),
        .s_axis_tready(s_axis_tready),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid),
        .busy         (busy),
        .frame_count  (frame_count)
    );

    always #5 clk = ~clk;

    // Records handshakes that will happen on the coming rising edge, then advances.
    task automatic step();
        if (m_axis_tvalid && m_axis_tready) begin
            oq_data.push_back(m_axis_tdata);
            oq_last.push_back(m_axis_tlast);
            oq_cyc.push_back(cyc);
        end
        if (s_axis_tvalid && s_axis_tready) acc_cyc.push_back(cyc);
        @(negedge clk);
        cyc++;
    endtask

    task automatic clear_q();
        oq_data.delete();
        oq_last.delete();
        oq_cyc.delete();
        acc_cyc.delete();
    endtask

    task automatic drive(input int n, input int first, input int en_drop, input int len_chg,
                         input logic [15:0] new_len, input bit rnd_v, input bit tog_r,
                         input bit drain);
        bit          pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int          t = 0;
        bit          stall_prev = 1'b0;
        logic [63:0] d_prev = '0;
        logic        l_prev = 1'b0;
        while (acc_cyc.size() < n && t < 400) begin
            if (stall_prev) begin
                vecs++;
                if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== d_prev || m_axis_tlast !== l_prev) begin
                    errs++;
                    $display("FAIL stall_hold: got v=%0b d=%h l=%0b, want v=1 d=%h l=%0b",
                             m_axis_tvalid, m_axis_tdata, m_axis_tlast, d_prev, l_prev);
                end
            end
            s_axis_tvalid = rnd_v ? 1'($urandom_range(0, 1)) : 1'b1;
            s_axis_tdata  = 64'(first + acc_cyc.size());
            m_axis_tready = tog_r ? pat[t % 4] : 1'b1;
            stall_prev    = m_axis_tvalid && !m_axis_tready;
            d_prev        = m_axis_tdata;
            l_prev        = m_axis_tlast;
            step();
            t++;
            vecs++;
            if (acc_cyc.size() - oq_data.size() > 2) begin
                errs++;
                $display("FAIL occupancy: got %0d buffered, want <= 2",
                         acc_cyc.size() - oq_data.size());
            end
            if (acc_cyc.size() == en_drop) enable = 1'b0;
            if (acc_cyc.size() == len_chg) frame_len = new_len;
        end
        s_axis_tvalid = 1'b0;
        if (t >= 400) begin
            errs++;
            $display("FAIL accept_timeout: got %0d accepted, want %0d", acc_cyc.size(), n);
        end
        if (drain) begin
            m_axis_tready = 1'b1;
            t = 0;
            while (oq_data.size() < n && t < 50) begin
                step();
                t++;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        enable = 1'b0;
        frame_len = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata = '0;
        m_axis_tready = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        vecs++;
        if ({s_axis_tready, m_axis_tvalid, m_axis_tlast, busy} !== 4'b0000) begin
            errs++;
            $display("FAIL reset_flags: got %b, want 0000",
                     {s_axis_tready, m_axis_tvalid, m_axis_tlast, busy});
        end
        vecs++;
        if (m_axis_tdata !== 64'd0 || frame_count !== 32'd0) begin
            errs++;
            $display("FAIL reset_data: got d=%h fc=%0d, want 0/0", m_axis_tdata, frame_count);
        end
        rst_n = 1'b1;
        step();
        vecs++;
        if (s_axis_tready !== 1'b0 || busy !== 1'b0) begin
            errs++;
            $display("FAIL idle_after_reset: got rdy=%0b busy=%0b, want 0/0", s_axis_tready, busy);
        end
    endtask

    task automatic test_basic();
        clear_q();
        enable = 1'b1;
        frame_len = 16'd4;
        drive(8, 1, 7, -1, 16'd0, 1'b0, 1'b0, 1'b1);
        vecs++;
        if (oq_data.size() != 8) begin
            errs++;
            $display("FAIL basic_count: got %0d beats, want 8", oq_data.size());
        end
        for (int i = 0; i < oq_data.size(); i++) begin
            vecs++;
            if (oq_data[i] !== 64'(i + 1) || oq_last[i] !== (i == 3 || i == 7)
                || oq_cyc[i] != oq_cyc[0] + i) begin
                errs++;
                $display("FAIL basic_beat%0d: got d=%h l=%0b c=%0d, want d=%h l=%0b c=%0d", i,
                         oq_data[i], oq_last[i], oq_cyc[i], 64'(i + 1), (i == 3 || i == 7),
                         oq_cyc[0] + i);
            end
        end
        vecs++;
        if (oq_cyc.size() == 0 || acc_cyc.size() == 0 || oq_cyc[0] != acc_cyc[0] + 1) begin
            errs++;
            $display("FAIL basic_latency: got first out cycle mismatch, want accept+1");
        end
        vecs++;
        if (frame_count !== 32'd2 || busy !== 1'b0 || s_axis_tready !== 1'b0) begin
            errs++;
            $display("FAIL basic_end: got fc=%0d busy=%0b rdy=%0b, want 2/0/0",
                     frame_count, busy, s_axis_tready);
        end
    endtask

    task automatic test_len_zero();
        logic [31:0] fc0 = frame_count;
        clear_q();
        enable = 1'b1;
        frame_len = 16'd0;
        drive(3, 'h100, 2, -1, 16'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            vecs++;
            if (i >= oq_data.size() || oq_data[i] !== 64'('h100 + i) || oq_last[i] !== 1'b1) begin
                errs++;
                $display("FAIL len0_beat%0d: wrong data or tlast, want d=%h l=1", i, 64'('h100 + i));
            end
        end
        vecs++;
        if (frame_count - fc0 !== 32'd3 || busy !== 1'b0) begin
            errs++;
            $display("FAIL len0_frames: got %0d frames busy=%0b, want 3/0", frame_count - fc0, busy);
        end
    endtask

    task automatic test_stall();
        logic [31:0] fc0 = frame_count;
        clear_q();
        enable = 1'b1;
        frame_len = 16'd3;
        drive(6, 'h200, 5, -1, 16'd0, 1'b1, 1'b1, 1'b1);
        vecs++;
        if (oq_data.size() != 6) begin
            errs++;
            $display("FAIL stall_count: got %0d beats, want 6", oq_data.size());
        end
        for (int i = 0; i < oq_data.size(); i++) begin
            vecs++;
            if (oq_data[i] !== 64'('h200 + i) || oq_last[i] !== (i == 2 || i == 5)) begin
                errs++;
                $display("FAIL stall_beat%0d: got d=%h l=%0b, want d=%h l=%0b", i, oq_data[i],
                         oq_last[i], 64'('h200 + i), (i == 2 || i == 5));
            end
        end
        vecs++;
        if (frame_count - fc0 !== 32'd2) begin
            errs++;
            $display("FAIL stall_frames: got %0d, want 2", frame_count - fc0);
        end
    endtask

    task automatic test_enable_drop();
        clear_q();
        enable = 1'b1;
        frame_len = 16'd5;
        drive(5, 'h300, 2, -1, 16'd0, 1'b0, 1'b0, 1'b1);
        vecs++;
        if (oq_data.size() != 5) begin
            errs++;
            $display("FAIL endrop_count: got %0d beats, want 5", oq_data.size());
        end
        for (int i = 0; i < oq_data.size(); i++) begin
            vecs++;
            if (oq_data[i] !== 64'('h300 + i) || oq_last[i] !== (i == 4)) begin
                errs++;
                $display("FAIL endrop_beat%0d: got d=%h l=%0b, want d=%h l=%0b", i, oq_data[i],
                         oq_last[i], 64'('h300 + i), (i == 4));
            end
        end
        s_axis_tvalid = 1'b1;
        repeat (3) step();
        s_axis_tvalid = 1'b0;
        vecs++;
        if (busy !== 1'b0 || s_axis_tready !== 1'b0 || acc_cyc.size() != 5) begin
            errs++;
            $display("FAIL endrop_idle: got busy=%0b rdy=%0b acc=%0d, want 0/0/5",
                     busy, s_axis_tready, acc_cyc.size());
        end
    endtask

    task automatic test_reset_mid();
        clear_q();
        enable = 1'b1;
        frame_len = 16'd4;
        drive(2, 'h400, -1, -1, 16'd0, 1'b0, 1'b0, 1'b0);
        m_axis_tready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        vecs++;
        if ({s_axis_tready, m_axis_tvalid, m_axis_tlast, busy} !== 4'b0000
            || m_axis_tdata !== 64'd0 || frame_count !== 32'd0) begin
            errs++;
            $display("FAIL reset_mid: got rdy=%0b v=%0b l=%0b busy=%0b d=%h fc=%0d, want all 0",
                     s_axis_tready, m_axis_tvalid, m_axis_tlast, busy, m_axis_tdata, frame_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        m_axis_tready = 1'b1;
        clear_q();
        drive(4, 'h500, 3, -1, 16'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            vecs++;
            if (i >= oq_data.size() || oq_data[i] !== 64'('h500 + i) || oq_last[i] !== (i == 3)) begin
                errs++;
                $display("FAIL after_reset_beat%0d: wrong data or tlast, want d=%h l=%0b", i,
                         64'('h500 + i), (i == 3));
            end
        end
        vecs++;
        if (frame_count !== 32'd1) begin
            errs++;
            $display("FAIL after_reset_frames: got %0d, want 1", frame_count);
        end
    endtask

    task automatic test_len_change();
        logic [31:0] fc0 = frame_count;
        clear_q();
        enable = 1'b1;
        frame_len = 16'd4;
        drive(6, 'h600, 5, 1, 16'd2, 1'b0, 1'b0, 1'b1);
        vecs++;
        if (oq_data.size() != 6) begin
            errs++;
            $display("FAIL lenchg_count: got %0d beats, want 6", oq_data.size());
        end
        for (int i = 0; i < oq_data.size(); i++) begin
            vecs++;
            if (oq_data[i] !== 64'('h600 + i) || oq_last[i] !== (i == 3 || i == 5)) begin
                errs++;
                $display("FAIL lenchg_beat%0d: got d=%h l=%0b, want d=%h l=%0b", i, oq_data[i],
                         oq_last[i], 64'('h600 + i), (i == 3 || i == 5));
            end
        end
        vecs++;
        if (frame_count - fc0 !== 32'd2 || busy !== 1'b0) begin
            errs++;
            $display("FAIL lenchg_frames: got %0d busy=%0b, want 2/0", frame_count - fc0, busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_len_zero();
        test_stall();
        test_enable_drop();
        test_reset_mid();
        test_len_change();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/axis_frame_tlast_gen.md
AXIS_FRAME_TLAST_GEN -- requirements
Module: axis_frame_tlast_gen

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, the tdata width in bits.
REQ-002 SHALL have parameter LEN_WIDTH, default 16, the width of the frame-length and beat counters.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic rising-edge.
REQ-004 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-005 SHALL have port enable, input, 1; when high, new frames may start.
REQ-006 SHALL have port frame_len, input, LEN_WIDTH, beats per frame, sampled at frame start.
REQ-007 SHALL have port s_axis_tready, output, 1, input-side ready.
REQ-008 SHALL have port s_axis_tdata, input, DATA_WIDTH, input data.
REQ-009 SHALL have port s_axis_tvalid, input, 1, input valid; the input has no tlast.
REQ-010 SHALL have port m_axis_tready, input, 1, ready from the downstream fork arbiter.
REQ-011 SHALL have port m_axis_tdata, output, DATA_WIDTH, output data.
REQ-012 SHALL have port m_axis_tlast, output, 1, high on the last beat of each generated frame.
REQ-013 SHALL have port m_axis_tvalid, output, 1, output valid.
REQ-014 SHALL have port busy, output, 1, high while state is RUN.
REQ-015 SHALL have port frame_count, output, 32, count of frames completed on the output.

Function
REQ-016 SHALL implement a two-state FSM: IDLE and RUN.
REQ-017 In IDLE, s_axis_tready SHALL be 0.
REQ-018 IDLE->RUN SHALL occur on the cycle after enable=1 is sampled.
REQ-019 On IDLE->RUN, the FSM SHALL latch len_q=frame_len and clear the beat counter.
REQ-020 frame_len=0 SHALL be treated as 1.
REQ-021 In RUN, an input beat SHALL be accepted when s_axis_tvalid && s_axis_tready.
REQ-022 Each accepted beat SHALL increment the beat counter.
REQ-023 The beat whose counter value equals len_q-1 SHALL be tagged tlast=1; all other beats SHALL be tagged tlast=0.
REQ-024 On accepting the tlast-tagged beat, the FSM SHALL return to IDLE if enable=0, else stay in RUN with len_q reloaded from frame_len and the counter cleared.
REQ-025 enable falling mid-frame SHALL NOT truncate the frame; the current frame SHALL complete.
REQ-026 The output SHALL be a 2-entry skid buffer (output register plus skid register).
REQ-027 s_axis_tready SHALL be a registered signal, high in RUN only when the skid register is empty.
REQ-028 Latency from input acceptance to m_axis_tvalid SHALL be 1 cycle.
REQ-029 Sustained throughput SHALL be 1 beat/cycle while m_axis_tready=1.
REQ-030 While m_axis_tvalid=1 and m_axis_tready=0, m_axis_tdata and m_axis_tlast SHALL hold stable.
REQ-031 No beat SHALL be dropped or duplicated.
REQ-032 frame_count SHALL increment by 1 on each output handshake with m_axis_tlast=1.
REQ-033 frame_count SHALL wrap from 0xFFFFFFFF to 0.
REQ-034 The beat counter SHALL be LEN_WIDTH bits wide and SHALL never wrap within a frame.
REQ-035 busy SHALL be 1 exactly when the state is RUN.

Reset
REQ-036 While rst_n=0, the block SHALL asynchronously set: state=IDLE, s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, busy=0, frame_count=0, len_q=0, beat counter=0, both buffer entries empty.
REQ-037 Reset asserted mid-frame SHALL discard all buffered beats.
REQ-038 After rst_n deasserts, the first output frame SHALL start fresh at beat 0.
REQ-039 rst_n deassertion SHALL be synchronised externally; the block needs no internal release logic.

Verification
REQ-040 enable=1, frame_len=4, continuous valid, m_axis_tready=1, data 1..8 -> output 1..8 on consecutive cycles; tlast on data 4 and 8; frame_count=2.
REQ-041 frame_len=0, three input beats -> every output beat has tlast=1; frame_count=3.
REQ-042 frame_len=3, m_axis_tready toggling 1,0,0,1 with random s_axis_tvalid -> output sequence equals input; data held stable while stalled; never more than 2 beats buffered.
REQ-043 frame_len=5, enable dropped after beat 2 -> beats 3..5 still accepted; tlast on beat 5; then busy=0 and s_axis_tready=0.
REQ-044 rst_n pulsed low after beat 2 of a 4-beat frame -> all outputs at reset values immediately; next frame's tlast on its 4th beat.
REQ-045 frame_len changed from 4 to 2 mid-frame -> current frame still 4 beats; the following frame is 2 beats.
